reg_file_2r1w: RTL

Parametrised register file with one write port and two independently enabled, registered read ports. Read data is write-first bypassed. Contents are cleared by a one-entry-per-cycle sweep engine, started by reset or by a `clear` request. An optional hardwired-zero entry 0 is available. It is the general storage block for datapath operands and configuration scratch, and replaces the single-read 8x16 file in new designs.

---
 rtl/reg_file_2r1w_if.sv | 30 +++
 rtl/reg_file_2r1w.sv | 135 +++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: clear/busy control, one write port and two
// registered read ports.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clear;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              re1;
    logic [ADDR_W-1:0] a1;
    logic              re2;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid1;
    logic              rvalid2;

    modport master (
        output clear, we, wa, wd, re1, a1, re2, a2,
        input  busy, rd1, rd2, rvalid1, rvalid2
    );

    modport slave (
        input  clear, we, wa, wd, re1, a1, re2, a2,
        output busy, rd1, rd2, rvalid1, rvalid2
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with write-first bypass, registered reads
// and a one-entry-per-cycle clear sweep started by reset or a clear request.
module reg_file_2r1w #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ZERO_REG0 = 0
) (
    input  logic            clock,
    input  logic            reset,
    reg_file_2r1w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_rvalid1;
    logic              r_rvalid2;

    logic              w_idle;
    logic              w_wr_en;
    logic              w_rd1_en;
    logic              w_rd2_en;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // ---------------- access qualification ----------------
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_wr_en  = w_idle && bus.we && !((ZERO_REG0 != 0) && (bus.wa == '0));
        w_rd1_en = w_idle && bus.re1;
        w_rd2_en = w_idle && bus.re2;
    end

    // Write-first bypass, then the hardwired-zero override wins over both.
    always_comb begin
        w_rd1_nxt = r_mem[bus.a1];
        if (bus.we && (bus.wa == bus.a1)) begin
            w_rd1_nxt = bus.wd;
        end
        if ((ZERO_REG0 != 0) && (bus.a1 == '0)) begin
            w_rd1_nxt = '0;
        end

        w_rd2_nxt = r_mem[bus.a2];
        if (bus.we && (bus.wa == bus.a2)) begin
            w_rd2_nxt = bus.wd;
        end
        if ((ZERO_REG0 != 0) && (bus.a2 == '0)) begin
            w_rd2_nxt = '0;
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_en) begin
                r_mem[bus.wa] <= bus.wd;
            end
        end
    end

    // ---------------- read ports ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_rvalid1 <= 1'b0;
            r_rvalid2 <= 1'b0;
        end else begin
            r_rvalid1 <= w_rd1_en;
            r_rvalid2 <= w_rd2_en;
            if (w_rd1_en) begin
                r_rd1 <= w_rd1_nxt;
            end
            if (w_rd2_en) begin
                r_rd2 <= w_rd2_nxt;
            end
        end
    end

    assign bus.busy    = (r_state == S_CLEAR);
    assign bus.rd1     = r_rd1;
    assign bus.rd2     = r_rd2;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rvalid2 = r_rvalid2;

endmodule
